seven_seg_capture: RTL

//   Receive side of the seven-segment display interface. Samples a multiplexed seven-segment
//   bus (one-hot digit enables plus segment lines), debounces each digit dwell and decodes
//   the segment pattern back to a hex nibble. Assembles an NUM_DIGITS-digit value and flags

---
 rtl/seven_seg_pkg.sv | 66 ++++++
 rtl/seven_seg_capture_if.sv | 34 +++
 rtl/seven_seg_capture_decode.sv | 16 +
 rtl/seven_seg_capture.sv | 116 +++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Seven-segment pattern constants and decode helper shared by the capture block and the encoder.
// Latency: none (constants and a pure function). Backpressure: not applicable.
// Bit order: bit0 = segment a .. bit6 = segment g, active-high.
package seven_seg_pkg;

    typedef logic [6:0] seg7_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] nibble;
    } seg7_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_COMMITTED
    } cap_state_t;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_A     = 7'h77;
    localparam seg7_t SEG_B     = 7'h7C;
    localparam seg7_t SEG_C     = 7'h39;
    localparam seg7_t SEG_D     = 7'h5E;
    localparam seg7_t SEG_E     = 7'h79;
    localparam seg7_t SEG_F     = 7'h71;
    localparam seg7_t SEG_BLANK = 7'h00;

    // Anything outside the sixteen glyphs (blank included) reports ok=0.
    function automatic seg7_dec_t seg7_decode(input seg7_t seg);
        seg7_dec_t d;
        d.ok = 1'b1;
        case (seg)
            SEG_0:   d.nibble = 4'h0;
            SEG_1:   d.nibble = 4'h1;
            SEG_2:   d.nibble = 4'h2;
            SEG_3:   d.nibble = 4'h3;
            SEG_4:   d.nibble = 4'h4;
            SEG_5:   d.nibble = 4'h5;
            SEG_6:   d.nibble = 4'h6;
            SEG_7:   d.nibble = 4'h7;
            SEG_8:   d.nibble = 4'h8;
            SEG_9:   d.nibble = 4'h9;
            SEG_A:   d.nibble = 4'hA;
            SEG_B:   d.nibble = 4'hB;
            SEG_C:   d.nibble = 4'hC;
            SEG_D:   d.nibble = 4'hD;
            SEG_E:   d.nibble = 4'hE;
            SEG_F:   d.nibble = 4'hF;
            default: begin
                d.ok     = 1'b0;
                d.nibble = 4'h0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bundle of the multiplexed display bus and the decoded capture results (dp lines with SEVEN_SEG_CAPTURE_DP_EN).
// Latency: none (wires only). Backpressure: none, the display bus is free-running.
// master drives the display bus and observes results; slave is the capture block.
interface seven_seg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an_in;
    logic [6:0]              seg_in;
    logic [4*NUM_DIGITS-1:0] value_o;
    logic [NUM_DIGITS-1:0]   digit_err_o;
    logic                    frame_valid_o;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [0:0]              dp_in;
    logic [NUM_DIGITS-1:0]   dp_o;

    modport master (
        output an_in, seg_in, dp_in,
        input  value_o, digit_err_o, frame_valid_o, dp_o
    );
    modport slave (
        input  an_in, seg_in, dp_in,
        output value_o, digit_err_o, frame_valid_o, dp_o
    );
`else
    modport master (
        output an_in, seg_in,
        input  value_o, digit_err_o, frame_valid_o
    );
    modport slave (
        input  an_in, seg_in,
        output value_o, digit_err_o, frame_valid_o
    );
`endif
endinterface

// File: rtl/seven_seg_capture_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Latency: 0 cycles. Backpressure: none.
// ok=0 flags a pattern that is not one of the sixteen hex glyphs.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  seg7_t      seg,
    output logic       ok,
    output logic [3:0] nibble
);
    seg7_dec_t dec;

    assign dec    = seg7_decode(seg);
    assign ok     = dec.ok;
    assign nibble = dec.nibble;
endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed seven-segment bus into NUM_DIGITS hex nibbles; SEVEN_SEG_CAPTURE_DP_EN adds dp capture.
// Latency: commit lands STABLE_CYCLES+2 edges after the raw bus settles (2 sync + stability count).
// Backpressure: none; the bus is sampled every cycle and results are plain registers plus a frame pulse.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_capture_if.slave bus
);
    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    localparam int             PW      = NUM_DIGITS + 8;
`else
    localparam int             PW      = NUM_DIGITS + 7;
`endif

    logic [PW-1:0]           raw, sync1, sync2, prev;
    logic [NUM_DIGITS-1:0]   an_s;
    seg7_t                   seg_s;
    logic                    dec_ok;
    logic [3:0]              dec_nib;
    logic                    onehot, same, commit;
    logic [CW-1:0]           cnt, cnt_inc;
    cap_state_t              state;
    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   err_r;
    logic                    frame_r;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [NUM_DIGITS-1:0]   dp_r;
    assign raw      = {bus.dp_in, bus.seg_in, bus.an_in};
    assign bus.dp_o = dp_r;
`else
    assign raw      = {bus.seg_in, bus.an_in};
`endif

    assign an_s  = sync2[NUM_DIGITS-1:0];
    assign seg_s = sync2[NUM_DIGITS +: 7];

    seven_seg_decode u_decode (
        .seg    (seg_s),
        .ok     (dec_ok),
        .nibble (dec_nib)
    );

    always_comb begin
        onehot   = $onehot(an_s);
        same     = (sync2 == prev);
        cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        commit   = onehot && same && (state != ST_COMMITTED) && (cnt_inc == CNT_MAX);
        seen_nxt = seen | (commit ? an_s : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            cnt     <= '0;
            state   <= ST_IDLE;
            seen    <= '0;
            value_r <= '0;
            err_r   <= '0;
            frame_r <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dp_r    <= '0;
`endif
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;

            // A changed but valid sample is itself the first of a new dwell, hence count=1.
            if (!onehot) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (!same) begin
                state <= ST_IDLE;
                cnt   <= CW'(1);
            end else if (state != ST_COMMITTED) begin
                cnt   <= cnt_inc;
                state <= commit ? ST_COMMITTED : ST_COUNT;
            end

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit && an_s[i]) begin
                    if (dec_ok) begin
                        value_r[4*i +: 4] <= dec_nib;
                    end
                    err_r[i] <= ~dec_ok;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
                    dp_r[i]  <= sync2[PW-1];
`endif
                end
            end

            if (&seen_nxt) begin
                frame_r <= 1'b1;
                seen    <= '0;
            end else begin
                frame_r <= 1'b0;
                seen    <= seen_nxt;
            end
        end
    end

    assign bus.value_o       = value_r;
    assign bus.digit_err_o   = err_r;
    assign bus.frame_valid_o = frame_r;
endmodule
